mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory port, downstream of the store path.
- Decodes the same address, write-data and write-enable signals that drive the block RAM port A during STORE/LOAD.
- Buffers stored bytes in a small FIFO and serializes them 8N1, LSB first, on a TX pin.
- Exposes a status word for LOAD so software can poll before storing.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); minimum 2
FIFO_DEPTH, 8, byte FIFO entries; power of two, minimum 2
TX_ADDR, 16'hFFF0, store here pushes wdata[7:0]; load returns 16'h0000
STAT_ADDR, 16'hFFF1, load returns status; store here clears overflow

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low
addr  input  16  data-memory address (same net as RAM port A address)
wdata  input  16  store data (register-file A bus)
we  input  1  memory write enable from control FSM
rd_data  output  16  registered read data, valid the cycle after addr is presented
hit  output  1  registered; 1 when the previous-cycle addr was TX_ADDR or STAT_ADDR (selects rd_data over RAM q_a)
tx  output  1  serial line, idles high
busy  output  1  high when the FIFO is non-empty or the serializer is not IDLE

Behaviour:
- Reset (rst=0, asynchronous): tx=1, state IDLE, FIFO empty, count=0, overflow=0, rd_data=0, hit=0, busy=0, bit/baud counters 0.
- Reads match the one-cycle latency of the RAM:
  - On each edge, hit <= (addr==TX_ADDR || addr==STAT_ADDR).
  - rd_data <= STAT_ADDR ? status : 16'h0000.
  - status = {11'b0, overflow, full, empty, busy, tx_state_active}.
  - tx_state_active = state != IDLE.
  - Reads have no side effects.
- Push: we=1 and addr==TX_ADDR.
  - If not full (see simultaneous rule), write wdata[7:0] at the write pointer; count+1.
  - If full, drop the byte and set overflow=1 (sticky).
  - wdata[15:8] is ignored.
- Clear: we=1 and addr==STAT_ADDR sets overflow <= 0. If an overflow event happens in the same cycle, clear wins.
- FIFO:
  - Circular, pointers log2(FIFO_DEPTH) bits wide, wrap modulo depth.
  - count is 0..FIFO_DEPTH; full = count==FIFO_DEPTH, empty = count==0.
- Simultaneous push and pop:
  - Full test uses the post-pop count, so a push when full and popping in the same cycle is accepted and count is unchanged.
  - Push and pop when empty is impossible, because a pop requires non-empty at the edge.
- Serializer FSM; each bit state lasts exactly CLKS_PER_BIT cycles, counted by a baud counter reset on every state entry:
  - IDLE: tx=1. If not empty, pop the head into an 8-bit shift register and go to START at that edge.
  - START: tx=0. After CLKS_PER_BIT cycles go to DATA with bit index 0.
  - DATA: tx=shift[0]. Each bit period, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - IDLE is occupied for at least one cycle between frames, so back-to-back frames are spaced 10*CLKS_PER_BIT+1 cycles.
  - Push at edge N makes the FIFO non-empty after N. IDLE pops at edge N+1, and tx falls after edge N+1.
- tx is driven from a register (no combinational glitches).
- Reset mid-frame: tx returns high immediately and the frame and FIFO contents are discarded.

Test Plan:
Use CLKS_PER_BIT=4, FIFO_DEPTH=4 in sim.
1. Reset with rst=0 mid-run -> tx=1, busy=0, hit=0, rd_data=0. Load STAT_ADDR after release -> rd_data=16'h0004 (empty only).
2. Store 16'hA555 to TX_ADDR -> tx low two edges later for 4 cycles. Then data bits 1,0,1,0,1,0,1,0 (8'h55 LSB first), 4 cycles each, then stop high. busy falls after 41 cycles. wdata[15:8] has no effect.
3. Store 6 bytes 01..06 on consecutive cycles -> first pops immediately, next four fill the FIFO, sixth dropped. Status reads full=1, overflow=1 (16'h0018 | busy bits). Exactly bytes 01..05 appear on tx with 41-cycle frame spacing.
4. Store to STAT_ADDR -> overflow cleared. When the FIFO is full and IDLE pops in the same cycle as a store to TX_ADDR, the byte is accepted, count stays 4 and overflow stays 0.
5. Load TX_ADDR and an unrelated address 16'h0010 -> hit=1, rd_data=0 for TX_ADDR. hit=0 for 16'h0010. No FIFO change.
6. Assert rst during DATA bit 3 -> tx=1 asynchronously, FIFO empty. After release, a new store transmits a clean full frame.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: stores to TX_ADDR queue bytes in a small FIFO that a
// serializer drains as 8N1 frames (LSB first); loads from STAT_ADDR return live status.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] TX_ADDR      = 16'hFFF0,
    parameter logic [15:0] STAT_ADDR    = 16'hFFF1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic [15:0] rd_data,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [7:0]        shift;
    logic [2:0]        bit_idx;
    logic [BAUD_W-1:0] baud;

    logic        full;
    logic        empty;
    logic        pop;
    logic        push_req;
    logic        push_ok;
    logic        clear_req;
    logic        tx_state_active;
    logic [15:0] status;
    logic        unused_wdata_hi;

    assign full            = (count == COUNT_FULL);
    assign empty           = (count == '0);
    assign tx_state_active = (state != IDLE);
    assign pop             = (state == IDLE) && !empty;
    assign push_req        = we && (addr == TX_ADDR);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the store.
    assign push_ok         = push_req && (!full || pop);
    assign clear_req       = we && (addr == STAT_ADDR);
    assign busy            = !empty || tx_state_active;
    assign status          = {11'b0, overflow, full, empty, busy, tx_state_active};
    assign unused_wdata_hi = &{1'b0, wdata[15:8]};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Software clearing the flag wins over a drop in the same cycle.
            if (clear_req) begin
                overflow <= 1'b0;
            end else if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit     <= 1'b0;
            rd_data <= '0;
        end else begin
            hit     <= (addr == TX_ADDR) || (addr == STAT_ADDR);
            rd_data <= (addr == STAT_ADDR) ? status : 16'h0000;
        end
    end

    // tx is registered alongside each transition so the line never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
            baud    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (!empty) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                    tx <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-and-frame-age model checked every cycle, plus a tx line
// decoder and hand-computed status/timing expectations.
module tb_mmio_uart_tx;

    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] TX_A   = 16'hFFF0;
    localparam logic [15:0] STAT_A = 16'hFFF1;
    localparam logic [15:0] IDLE_A = 16'h0100;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [15:0] addr  = IDLE_A;
    logic [15:0] wdata = 16'h0000;
    logic        we    = 1'b0;
    logic [15:0] rd_data;
    logic        hit;
    logic        tx;
    logic        busy;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic tx_log [0:4095];

    logic [7:0]  mq [$];
    logic        m_active = 1'b0;
    int          m_age    = 0;
    logic [7:0]  m_byte   = 8'h00;
    logic        m_ovf    = 1'b0;
    logic [15:0] m_rd     = 16'h0000;
    logic        m_hit    = 1'b0;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .TX_ADDR     (TX_A),
        .STAT_ADDR   (STAT_A)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .rd_data(rd_data),
        .hit    (hit),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Frame bit j of 10 (start, 8 data LSB first, stop) is on the line for CPB cycles.
    function automatic logic modelTx();
        int j;
        if (!m_active) return 1'b1;
        j = m_age / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return m_byte[j-1];
        return 1'b1;
    endfunction

    function automatic logic modelBusy();
        return (mq.size() != 0) || m_active;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_active = 1'b0;
            m_age    = 0;
            m_ovf    = 1'b0;
            m_rd     = 16'h0000;
            m_hit    = 1'b0;
        end else begin
            logic [15:0] st;
            logic        drop;
            st = {11'b0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0), modelBusy(), m_active};
            m_hit = (addr == TX_A) || (addr == STAT_A);
            m_rd  = (addr == STAT_A) ? st : 16'h0000;
            if (m_active) begin
                m_age = m_age + 1;
                if (m_age == 10 * CPB) m_active = 1'b0;
            end else if (mq.size() > 0) begin
                m_byte   = mq.pop_front();
                m_active = 1'b1;
                m_age    = 0;
            end
            drop = 1'b0;
            if (we && addr == TX_A) begin
                if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
                else drop = 1'b1;
            end
            if (we && addr == STAT_A) m_ovf = 1'b0;
            else if (drop) m_ovf = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cyc < 4096) tx_log[cyc] = tx;
        checkOutput("model tx", 16'(tx), 16'(modelTx()));
        checkOutput("model busy", 16'(busy), 16'(modelBusy()));
        checkOutput("model hit", 16'(hit), 16'(m_hit));
        checkOutput("model rd_data", rd_data, m_rd);
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] w, input logic e);
        addr  = a;
        wdata = w;
        we    = e;
        @(negedge clk);
        addr  = IDLE_A;
        we    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic loadCheck(input logic [15:0] a, input logic [15:0] exp_rd, input logic exp_hit);
        applyStimulus(a, 16'h0000, 1'b0);
        checkOutput("load rd_data", rd_data, exp_rd);
        checkOutput("load hit", 16'(hit), 16'(exp_hit));
    endtask

    // Independent line receiver: samples mid-bit after each falling edge of an idle line.
    task automatic decodeFrames(input int from_c, input int n_exp, input logic [63:0] exp_bytes);
        int nf;
        int last;
        int to_c;
        nf   = 0;
        last = -1;
        to_c = cyc - 10 * CPB;
        for (int c = from_c + 1; c <= to_c; c++) begin
            if (tx_log[c-1] === 1'b1 && tx_log[c] === 1'b0) begin
                logic [7:0] b;
                for (int i = 0; i < 8; i++) b[i] = tx_log[c + CPB + CPB * i + CPB / 2];
                checkOutput("frame stop bit", 16'(tx_log[c + 9 * CPB + CPB / 2]), 16'h0001);
                if (nf < n_exp) checkOutput("frame byte", 16'(b), 16'(exp_bytes[8*nf +: 8]));
                if (last >= 0) checkOutput("frame spacing", 16'(c - last), 16'(10 * CPB + 1));
                last = c;
                nf   = nf + 1;
                c    = c + 10 * CPB - 1;
            end
        end
        checkOutput("frame count", 16'(nf), 16'(n_exp));
    endtask

    initial begin
        int         start_c;
        logic [9:0] frame;

        // Reset, then reset again mid-frame
        idleCycles(3);
        checkOutput("reset tx", 16'(tx), 16'h0001);
        checkOutput("reset busy", 16'(busy), 16'h0000);
        checkOutput("reset hit", 16'(hit), 16'h0000);
        checkOutput("reset rd_data", rd_data, 16'h0000);
        rst = 1'b1;
        applyStimulus(TX_A, 16'h003C, 1'b1);
        idleCycles(6);
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset tx", 16'(tx), 16'h0001);
        checkOutput("async reset busy", 16'(busy), 16'h0000);
        checkOutput("async reset hit", 16'(hit), 16'h0000);
        checkOutput("async reset rd_data", rd_data, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        loadCheck(STAT_A, 16'h0004, 1'b1);

        // Single frame of 8'h55; the high byte of wdata is ignored
        frame = {1'b1, 8'h55, 1'b0};
        applyStimulus(TX_A, 16'hA555, 1'b1);
        checkOutput("frame busy k0", 16'(busy), 16'h0001);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            checkOutput("frame tx", 16'(tx), (k <= 40) ? 16'(frame[(k-1)/4]) : 16'h0001);
            checkOutput("frame busy", 16'(busy), (k <= 40) ? 16'h0001 : 16'h0000);
        end
        idleCycles(4);

        // Six back-to-back stores into a four-entry FIFO: the sixth is dropped
        start_c = cyc;
        for (int i = 1; i <= 6; i++) applyStimulus(TX_A, 16'(i), 1'b1);
        loadCheck(STAT_A, 16'h001B, 1'b1);
        idleCycles(250);
        decodeFrames(start_c, 5, 64'h0000_0005_0403_0201);
        loadCheck(STAT_A, 16'h0014, 1'b1);

        // Clear overflow, then store into a full FIFO on the cycle IDLE pops
        applyStimulus(STAT_A, 16'h0000, 1'b1);
        loadCheck(STAT_A, 16'h0004, 1'b1);
        start_c = cyc;
        applyStimulus(TX_A, 16'h0011, 1'b1);
        applyStimulus(TX_A, 16'h0022, 1'b1);
        applyStimulus(TX_A, 16'h0033, 1'b1);
        applyStimulus(TX_A, 16'h0044, 1'b1);
        applyStimulus(TX_A, 16'h0055, 1'b1);
        idleCycles(37);
        applyStimulus(TX_A, 16'h0066, 1'b1);
        loadCheck(STAT_A, 16'h000B, 1'b1);
        idleCycles(260);
        decodeFrames(start_c, 6, 64'h0000_6655_4433_2211);
        loadCheck(STAT_A, 16'h0004, 1'b1);

        // Loads to TX_ADDR and an unrelated address
        loadCheck(TX_A, 16'h0000, 1'b1);
        loadCheck(16'h0010, 16'h0000, 1'b0);
        loadCheck(STAT_A, 16'h0004, 1'b1);

        // Reset during data bit 3 of 8'hC3 with another byte queued
        applyStimulus(TX_A, 16'h00C3, 1'b1);
        applyStimulus(TX_A, 16'h007E, 1'b1);
        idleCycles(17);
        checkOutput("bit3 tx before reset", 16'(tx), 16'h0000);
        checkOutput("bit3 busy before reset", 16'(busy), 16'h0001);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid-frame reset tx", 16'(tx), 16'h0001);
        checkOutput("mid-frame reset busy", 16'(busy), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        loadCheck(STAT_A, 16'h0004, 1'b1);
        start_c = cyc;
        applyStimulus(TX_A, 16'h0096, 1'b1);
        idleCycles(100);
        decodeFrames(start_c, 1, 64'h0000_0000_0000_0096);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
